// File: rtl/adder_accumulate_ctrl.sv
// -----------------------------------------------------------------------------
// adder_accumulate_ctrl
//
// Sequencing controller that sits on the inputs and output of an external
// combinational adder. It accepts a stream of len_i operands over a
// valid/ready handshake. Each operand is added to the running sum: the
// accumulator goes out on add_a_o, the operand passes through on add_b_o,
// and the adder result add_s_i is captured back into the accumulator. When
// the stream ends it reports the final sum, a sticky unsigned-wrap flag and a
// one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start_i      begin a new accumulation (sampled only while idle)
//   len_i        number of operands, sampled with start_i
//   in_valid_i   operand valid
//   in_data_i    operand
//   in_ready_o   operand accepted this cycle when in_valid_i is high
//   add_a_o      to adder a: accumulator register
//   add_b_o      to adder b: in_data_i pass-through
//   add_s_i      from adder s
//   sum_o        accumulator value
//   overflow_o   sticky: at least one addition wrapped
//   count_o      operands accepted in the current/last run
//   busy_o       high while accumulating and in the done cycle
//   done_o       one-cycle pulse, final result valid
// -----------------------------------------------------------------------------
module adder_accumulate_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] len_i,
    input  logic                   in_valid_i,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    output logic                   in_ready_o,
    output logic [DATA_WIDTH-1:0]  add_a_o,
    output logic [DATA_WIDTH-1:0]  add_b_o,
    input  logic [DATA_WIDTH-1:0]  add_s_i,
    output logic [DATA_WIDTH-1:0]  sum_o,
    output logic                   overflow_o,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  ACC_ZERO = {DATA_WIDTH{1'b0}};

    state_t                   state_q,     state_d;
    logic [DATA_WIDTH-1:0]    acc_q,       acc_d;
    logic                     overflow_q,  overflow_d;
    logic [COUNT_WIDTH-1:0]   count_q,     count_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic                     in_ready_q,  in_ready_d;
    logic                     busy_q,      busy_d;
    logic                     done_q,      done_d;

    logic                     fire_s;
    logic                     wrap_s;

    // Handshake and wrap detection. in_ready_q is high exactly in the
    // accumulate state, so it doubles as the state qualifier for a fire.
    // With no carry out, a modular sum smaller than the old accumulator
    // means the addition wrapped.
    always_comb begin
        fire_s = in_valid_i & in_ready_q;
        wrap_s = (add_s_i < acc_q);
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        overflow_d  = overflow_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                if (start_i) begin
                    acc_d       = ACC_ZERO;
                    overflow_d  = 1'b0;
                    count_d     = CNT_ZERO;
                    remaining_d = len_i;
                    busy_d      = 1'b1;
                    if (len_i != CNT_ZERO) begin
                        state_d    = ST_ACC;
                        in_ready_d = 1'b1;
                    end else begin
                        // Empty stream: report a zero result right away.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACC: begin
                if (fire_s) begin
                    acc_d       = add_s_i;
                    overflow_d  = overflow_q | wrap_s;
                    count_d     = count_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d    = ST_DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    // Bubble: everything holds while in_data_i is ignored.
                    state_d = ST_ACC;
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and datapath registers, including the registered handshake and
    // status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_ZERO;
            overflow_q  <= 1'b0;
            count_q     <= CNT_ZERO;
            remaining_q <= CNT_ZERO;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The operand goes straight to the adder so its sum is ready this cycle.
    assign add_a_o    = acc_q;
    assign add_b_o    = in_data_i;
    assign sum_o      = acc_q;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;
    assign in_ready_o = in_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
module tb_adder_accumulate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] len_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_ready_o;
    logic [7:0] add_a_o;
    logic [7:0] add_b_o;
    logic [7:0] add_s_i;
    logic [7:0] sum_o;
    logic       overflow_o;
    logic [3:0] count_o;
    logic       busy_o;
    logic       done_o;

    adder_accumulate_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .add_a_o    (add_a_o),
        .add_b_o    (add_b_o),
        .add_s_i    (add_s_i),
        .sum_o      (sum_o),
        .overflow_o (overflow_o),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // The external combinational adder normally connected at the parent.
    assign add_s_i = add_a_o + add_b_o;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int sum;
        int ovf;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    int data_a[16];
    int gap_a[16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_x = sb.pop_front();
                chk("sum",        int'(sum_o),      mon_x.sum);
                chk("overflow",   int'(overflow_o), mon_x.ovf);
                chk("count",      int'(count_o),    mon_x.cnt);
                chk("done_cycle", cyc,              mon_x.cyc);
                chk("busy_in_done",  int'(busy_o),     1);
                chk("ready_in_done", int'(in_ready_o), 0);
            end
        end
    end

    // Drives one run using data_a/gap_a; time is #1 after an edge on entry
    // and exit. The expected result is computed from plain integer sums.
    task automatic run(input int n, input bit poke_start);
        int e;
        int tot;
        int bub;
        start_i = 1'b1;
        len_i   = 4'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i   = 4'($urandom_range(0, 15));
        e   = cyc;
        tot = 0;
        bub = 0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap_a[k]; g++) begin
                in_valid_i = 1'b0;
                in_data_i  = 8'($urandom_range(0, 255));
                chk("acc_hold_bubble", int'(add_a_o), tot % 256);
                @(posedge clk); #1;
                bub++;
            end
            in_valid_i = 1'b1;
            in_data_i  = 8'(data_a[k]);
            chk("ready_in_acc", int'(in_ready_o), 1);
            chk("busy_in_acc",  int'(busy_o), 1);
            if (poke_start && k == n / 2) begin
                start_i = 1'b1;
                len_i   = 4'($urandom_range(0, 15));
            end
            tot += data_a[k];
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        in_valid_i = 1'b0;
        sb.push_back('{tot % 256, (tot >= 256) ? 1 : 0, n, e + n + bub});
        // DONE cycle, then back to idle.
        @(posedge clk); #1;
        chk("result_consumed", sb.size(), 0);
        chk("idle_after_done", int'(busy_o), 0);
    endtask

    task automatic clear_gaps();
        for (int k = 0; k < 16; k++) gap_a[k] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        len_i      = 4'd0;
        in_valid_i = 1'b1;
        in_data_i  = 8'd0;
        clear_gaps();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: nothing moves even with in_valid high.
        for (int i = 0; i < 5; i++) begin
            in_data_i = 8'($urandom_range(0, 255));
            chk("rst_in_ready", int'(in_ready_o), 0);
            chk("rst_done",     int'(done_o), 0);
            chk("rst_busy",     int'(busy_o), 0);
            chk("rst_sum",      int'(sum_o), 0);
            @(posedge clk); #1;
        end
        chk("rst_count",    int'(count_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        chk("rst_add_a",    int'(add_a_o), 0);
        in_valid_i = 1'b0;

        // Basic stream.
        data_a[0] = 10; data_a[1] = 20; data_a[2] = 30;
        run(3, 1'b0);

        // Wrapping stream, then a clean one clears the flag.
        data_a[0] = 200; data_a[1] = 100;
        run(2, 1'b0);
        data_a[0] = 7;
        run(1, 1'b0);

        // Bubbles between operands.
        data_a[0] = 5; data_a[1] = 9; gap_a[1] = 2;
        run(2, 1'b0);
        clear_gaps();

        // Zero length.
        run(0, 1'b0);

        // Start pulsed mid-stream is ignored.
        data_a[0] = 1; data_a[1] = 2; data_a[2] = 3; data_a[3] = 4;
        run(4, 1'b1);

        // Async reset mid-run after two accepts.
        start_i = 1'b1;
        len_i   = 4'd4;
        @(posedge clk); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'd200;
        @(posedge clk); #1;
        in_data_i  = 8'd100;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready_o), 0);
        chk("midrst_busy",     int'(busy_o), 0);
        chk("midrst_sum",      int'(sum_o), 0);
        chk("midrst_overflow", int'(overflow_o), 0);
        chk("midrst_count",    int'(count_o), 0);
        chk("midrst_add_a",    int'(add_a_o), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        // No fresh start: stays idle and produces no done.
        for (int i = 0; i < 3; i++) begin
            chk("postrst_idle", int'(busy_o), 0);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        data_a[0] = 3;
        run(1, 1'b0);

        // Randomized runs, sometimes back-to-back, sometimes with idle gaps.
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) begin
                data_a[k] = $urandom_range(0, 255);
                gap_a[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            run(n, ($urandom_range(0, 3) == 0));
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                in_valid_i = 1'($urandom_range(0, 1));
                chk("idle_ready", int'(in_ready_o), 0);
                @(posedge clk); #1;
            end
            in_valid_i = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_accumulate_ctrl.md
# adder_accumulate_ctrl

Sequencing controller wrapped around the combinational dataflow adder: accepts a stream of `len` operands over a valid/ready handshake and drives the adder's `a`/`b` inputs with the running sum and the incoming operand. It registers the adder's `s` output back into the accumulator and reports the final sum, a sticky unsigned-overflow flag and a one-cycle `done` pulse. It sits directly on the adder's inputs and output; the adder instance is external and connected at the parent level.

## Interface
- `DATA_WIDTH`, 8: operand, accumulator and adder width; must match the adder instance.
- `COUNT_WIDTH`, 4: width of `len` and `count`; max stream length 2^COUNT_WIDTH−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `len`  in  COUNT_WIDTH  number of operands; sampled with `start`.
- `in_valid`  in  1  operand valid.
- `in_data`  in  DATA_WIDTH  operand.
- `in_ready`  out  1  block accepts operand this cycle.
- `add_a`  out  DATA_WIDTH  to adder `a`: accumulator register.
- `add_b`  out  DATA_WIDTH  to adder `b`: `in_data` pass-through.
- `add_s`  in  DATA_WIDTH  from adder `s`.
- `sum`  out  DATA_WIDTH  accumulator value.
- `overflow`  out  1  sticky: at least one addition wrapped.
- `count`  out  COUNT_WIDTH  operands accepted in current/last run.
- `busy`  out  1  high in ACC and DONE.
- `done`  out  1  one-cycle pulse, final result valid.

## Operation
- States: IDLE, ACC, DONE. Encoding is free.
- IDLE: `in_ready`=0. On `start`=1:
  - with `len`≠0: clear `acc`, `overflow` and `count`, load `remaining`=`len`, go to ACC.
  - with `len`=0: clear `acc`, `overflow` and `count`, go to DONE.
- ACC: `in_ready`=1. Handshake fires when `in_valid`&`in_ready`. On fire:
  - `acc`←`add_s`.
  - `overflow`←`overflow` | (`add_s` < `acc`), unsigned compare.
  - `count`←`count`+1, `remaining`←`remaining`−1.
  - if `remaining`=1 before the decrement, go to DONE.
- ACC without fire: all registers hold; `in_data` may change freely.
- DONE: `done`=1, `in_ready`=0, then unconditionally to IDLE.
- `start` in ACC or DONE is ignored; no restart or abort.
- `add_a`=`acc` (registered); `add_b`=`in_data` (combinational). The adder is purely combinational, so `add_s` is consumed in the same cycle.
- Arithmetic is modulo 2^DATA_WIDTH; there is no carry out. Overflow is detected only by the wrap compare.
- `sum`, `overflow` and `count` hold their final values in IDLE until the next accepted `start`.
- `busy`=1 in ACC and DONE.

## Timing
- Reset (async assert, takes effect immediately): state=IDLE, `acc`=0, `sum`=0, `overflow`=0, `count`=0, `in_ready`=0, `busy`=0, `done`=0, `add_a`=0.
- `rst` mid-run abandons the run; no `done` is produced. Recovery needs a fresh `start`.
- `start` is sampled at edge E; `in_ready` is first high in the cycle after E.
- With `in_valid` held high, N operands are accepted on N consecutive edges. `done` is high for the cycle following the last accept.
- Start-to-done latency is N+1 edges with no bubbles; each idle `in_valid` cycle adds one.
- `len`=0: `done` is high in the cycle after the `start` edge, with `sum`=0.
- Back-to-back runs: earliest next `start` is sampled in the IDLE cycle after DONE. Minimum period is N+2 cycles.
- `sum` and `overflow` reflect the final result in the same cycle `done` is high.

## Test plan
- Reset then idle: `rst` pulse → all outputs 0, `in_ready`=0 across 5 cycles with `in_valid`=1.
- Basic stream: `len`=3, data 10, 20, 30 with `in_valid` held → `done` on the 4th cycle after start, `sum`=60, `overflow`=0, `count`=3.
- Wrap: `len`=2, data 200, 100 → `sum`=44, `overflow`=1. Follow with a run of `len`=1, data 7 → `sum`=7, `overflow`=0.
- Bubbles: `len`=2, data 5, then 2 idle cycles, then data 9 → `sum`=14, `done` 5 cycles after start; `acc` unchanged during the bubbles.
- Zero length and ignored start:
  - `len`=0 → `done` in the next cycle, `sum`=0, `count`=0.
  - `start` pulsed mid-ACC → run unaffected.
- Async reset mid-run: `len`=4, `rst` asserted after 2 accepts → immediate return to reset values, no `done`. Then a new `len`=1 run with data 3 → `sum`=3.
